mp3_ser: RTL and testbench
==========================

// Module: mp3_ser
// PURPOSE
//  Byte FIFO and serializer that drives the MP3 decoder serial data input
//  (mp3_clk/mp3_dat/mp3_sync, flow control via mp3_req). It sits between the
//  CPU/DMA data path and the external decoder, downstream of SD reads.
//  Bytes are shifted out MSB first, and only while the decoder asserts mp3_req.
// PARAMETERS
//  DEPTH_LOG2  4  FIFO depth = 2**DEPTH_LOG2 bytes (16)
//  CLKDIV      2  mp3_clk half-period, in clk cycles (>=1)
// PORTS
//  clk        in   1  system clock; all logic is on the rising edge
//  rst        in   1  asynchronous reset, active-high
//  wr_stb     in   1  one-cycle write strobe for wr_data
//  wr_data    in   8  byte to enqueue
//  flush      in   1  synchronous: empty the FIFO and abort the byte in flight
//  ovf_clr    in   1  synchronous: clear ovf
//  full       out  1  FIFO holds 2**DEPTH_LOG2 bytes
//  empty      out  1  FIFO holds 0 bytes
//  level      out  DEPTH_LOG2+1  current byte count
//  ovf        out  1  sticky: a write was dropped because the FIFO was full
//  busy       out  1  serializer is not IDLE
//  mp3_req    in   1  decoder data request; asynchronous, high = send
//  mp3_clk    out  1  serial clock; decoder samples mp3_dat on the rising edge
//  mp3_dat    out  1  serial data
//  mp3_sync   out  1  high during the first bit (bit 7) of each byte
// BEHAVIOUR
//  Reset (async rst=1): FIFO pointers=0, level=0, empty=1, full=0, ovf=0,
//   busy=0, mp3_clk=0, mp3_dat=0, mp3_sync=0, state=IDLE, sync FFs=0.
//  mp3_req passes through a 2-FF synchronizer to give req_s (2-cycle latency).
//  FIFO:
//   - A write is accepted when wr_stb=1 and full=0 (full as seen before the
//     edge). level/empty/full update on the next edge.
//   - wr_stb=1 while full=1: the byte is dropped and ovf<=1, even if a pop
//     happens in the same cycle.
//   - Write and pop in the same cycle: both take effect; level is unchanged.
//   - Pointers are DEPTH_LOG2 bits wide and wrap modulo the depth.
//     level = wr_cnt - rd_cnt, DEPTH_LOG2+1 bits.
//   - ovf_clr clears ovf. If ovf_clr and an overflowing write occur in the
//     same cycle, the set wins.
//  Serializer FSM, all outputs registered:
//   IDLE : busy=0, mp3_clk=0. If empty=0 and req_s=1: pop a byte into
//          shreg, set bitcnt=7, load mp3_dat=byte[7], mp3_sync=1, divcnt=0,
//          go to LOW.
//   LOW  : mp3_clk=0 for CLKDIV cycles, then mp3_clk<=1 and go to HIGH.
//   HIGH : mp3_clk=1 for CLKDIV cycles, then mp3_clk<=0 and:
//          - bitcnt>0: bitcnt-1, mp3_dat<=next bit, mp3_sync<=0, go to LOW.
//          - bitcnt=0 and (empty=0 and req_s=1): pop the next byte directly
//            (back-to-back, as in IDLE), go to LOW.
//          - bitcnt=0 otherwise: mp3_dat<=0, mp3_sync<=0, go to IDLE.
//   - One byte lasts exactly 16*CLKDIV clk cycles. mp3_dat/mp3_sync change
//     only on mp3_clk falling edges, or on entry from IDLE while mp3_clk=0.
//   - req_s is checked only at byte boundaries. A byte in flight always
//     completes, even if mp3_req drops.
//   - Latency: a write at edge N to an empty FIFO with req_s=1 gives empty=0
//     after N. The pop happens at N+1, so mp3_sync=1 and busy=1 from N+1.
//  flush: pointers<=0, serializer to IDLE, mp3_clk/mp3_dat/mp3_sync<=0.
//   A write in the same cycle is discarded. ovf is unaffected.
//   flush has priority over everything except rst.
//  rst mid-byte aborts immediately to the reset values; no partial clock
//   pulse is stretched.
// TESTING
//  1 Reset: rst=1 with random inputs -> all outputs at their reset values;
//    release rst -> level=0, empty=1.
//  2 Single byte: mp3_req=1 for 3 cycles, write 8'hA5 -> mp3_dat over 8
//    mp3_clk rises reads 1,0,1,0,0,1,0,1; mp3_sync=1 only for the first bit;
//    busy drops after 16*CLKDIV cycles.
//  3 Flow control: mp3_req=0, write 3 bytes -> level=3, no mp3_clk edges;
//    raise mp3_req -> 3 bytes back-to-back, no idle cycle between them;
//    drop mp3_req mid-byte 2 -> byte 2 completes, byte 3 is held.
//  4 Overflow: mp3_req=0, write 17 bytes 0..16 -> full=1, level=16, ovf=1;
//    byte 16 lost; raise mp3_req -> bytes 0..15 come out in order; ovf_clr -> ovf=0.
//  5 Wrap and simultaneous events: stream 40 bytes with wr_stb every 5th cycle
//    (CLKDIV=1) -> output equals input, level never exceeds 16; check a
//    write+pop cycle keeps level unchanged.
//  6 flush / rst mid-byte: flush during bit 3 -> outputs to 0 the next cycle,
//    level=0, busy=0; then write 8'h3C -> sent cleanly; repeat using rst.

Source files
------------

// File: rtl/mp3_ser.sv
// Byte FIFO plus MSB-first serializer feeding the MP3 decoder serial input.
// Bytes are sent only while the decoder requests data; a started byte always completes.
module mp3_ser #(
  parameter int unsigned DEPTH_LOG2 = 4,
  parameter int unsigned CLKDIV     = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_stb,
  input  logic [7:0]            wr_data,
  input  logic                  flush,
  input  logic                  ovf_clr,
  output logic                  full,
  output logic                  empty,
  output logic [DEPTH_LOG2:0]   level,
  output logic                  ovf,
  output logic                  busy,
  input  logic                  mp3_req,
  output logic                  mp3_clk,
  output logic                  mp3_dat,
  output logic                  mp3_sync
);

  localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
  localparam int unsigned PTR_W = DEPTH_LOG2;
  localparam int unsigned LVL_W = DEPTH_LOG2 + 1;
  localparam int unsigned DIV_W = (CLKDIV > 1) ? $clog2(CLKDIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLKDIV - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOW  = 2'd1,
    HIGH = 2'd2
  } state_t;

  logic             req_m;
  logic             req_s;
  logic [7:0]       mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  state_t           state;
  logic [DIV_W-1:0] divcnt;
  logic [2:0]       bitcnt;
  logic [7:0]       shreg;

  logic             wr_ok_c;
  logic             byte_end_c;
  logic             pop_c;
  logic [LVL_W-1:0] level_nxt_c;
  logic [7:0]       rd_byte_c;

  // Accept/pop decisions shared by the FIFO and the serializer
  always_comb begin
    wr_ok_c     = wr_stb && !full && !flush;
    byte_end_c  = (state == HIGH) && (divcnt == DIV_LAST) && (bitcnt == 3'd0);
    pop_c       = !flush && !empty && req_s && ((state == IDLE) || byte_end_c);
    level_nxt_c = level + LVL_W'(wr_ok_c) - LVL_W'(pop_c);
    rd_byte_c   = mem[rd_ptr];
  end

  // Two-stage synchronizer for the asynchronous decoder request
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      req_m <= 1'b0;
      req_s <= 1'b0;
    end else begin
      req_m <= mp3_req;
      req_s <= req_m;
    end
  end

  // FIFO storage; contents need no reset
  always_ff @(posedge clk) begin
    if (wr_ok_c) mem[wr_ptr] <= wr_data;
  end

  // FIFO pointers, level and status flags
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
      empty  <= 1'b1;
      full   <= 1'b0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
      empty  <= 1'b1;
      full   <= 1'b0;
    end else begin
      if (wr_ok_c) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop_c)   rd_ptr <= rd_ptr + PTR_W'(1);
      level <= level_nxt_c;
      empty <= (level_nxt_c == '0);
      full  <= (level_nxt_c == LVL_W'(DEPTH));
    end
  end

  // Sticky overflow flag; a dropped write beats a simultaneous clear
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ovf <= 1'b0;
    end else if (wr_stb && full && !flush) begin
      ovf <= 1'b1;
    end else if (ovf_clr) begin
      ovf <= 1'b0;
    end
  end

  // Serializer FSM: LOW/HIGH halves of each bit, back-to-back byte chaining
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      busy     <= 1'b0;
      mp3_clk  <= 1'b0;
      mp3_dat  <= 1'b0;
      mp3_sync <= 1'b0;
      divcnt   <= '0;
      bitcnt   <= '0;
      shreg    <= '0;
    end else if (flush) begin
      state    <= IDLE;
      busy     <= 1'b0;
      mp3_clk  <= 1'b0;
      mp3_dat  <= 1'b0;
      mp3_sync <= 1'b0;
      divcnt   <= '0;
      bitcnt   <= '0;
    end else begin
      case (state)
        IDLE: begin
          busy    <= 1'b0;
          mp3_clk <= 1'b0;
          if (pop_c) begin
            shreg    <= {rd_byte_c[6:0], 1'b0};
            bitcnt   <= 3'd7;
            mp3_dat  <= rd_byte_c[7];
            mp3_sync <= 1'b1;
            divcnt   <= '0;
            busy     <= 1'b1;
            state    <= LOW;
          end
        end
        LOW: begin
          if (divcnt == DIV_LAST) begin
            divcnt  <= '0;
            mp3_clk <= 1'b1;
            state   <= HIGH;
          end else begin
            divcnt <= divcnt + DIV_W'(1);
          end
        end
        HIGH: begin
          if (divcnt == DIV_LAST) begin
            divcnt  <= '0;
            mp3_clk <= 1'b0;
            if (bitcnt != 3'd0) begin
              bitcnt   <= bitcnt - 3'd1;
              mp3_dat  <= shreg[7];
              shreg    <= {shreg[6:0], 1'b0};
              mp3_sync <= 1'b0;
              state    <= LOW;
            end else if (pop_c) begin
              shreg    <= {rd_byte_c[6:0], 1'b0};
              bitcnt   <= 3'd7;
              mp3_dat  <= rd_byte_c[7];
              mp3_sync <= 1'b1;
              state    <= LOW;
            end else begin
              mp3_dat  <= 1'b0;
              mp3_sync <= 1'b0;
              busy     <= 1'b0;
              state    <= IDLE;
            end
          end else begin
            divcnt <= divcnt + DIV_W'(1);
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mp3_ser.sv
// Scoreboard bench for mp3_ser: accepted bytes are queued in order, the
// monitor rebuilds bytes from mp3_dat at mp3_clk rises and compares.
module tb_mp3_ser;

  localparam int unsigned DL    = 4;
  localparam int unsigned DIV   = 2;
  localparam int unsigned DEPTH = 16;

  logic       clk = 1'b0;
  logic       rst;
  logic       wr_stb;
  logic [7:0] wr_data;
  logic       flush;
  logic       ovf_clr;
  logic       full;
  logic       empty;
  logic [DL:0] level;
  logic       ovf;
  logic       busy;
  logic       mp3_req;
  logic       mp3_clk;
  logic       mp3_dat;
  logic       mp3_sync;

  mp3_ser #(.DEPTH_LOG2(DL), .CLKDIV(DIV)) dut (
    .clk(clk), .rst(rst), .wr_stb(wr_stb), .wr_data(wr_data),
    .flush(flush), .ovf_clr(ovf_clr), .full(full), .empty(empty),
    .level(level), .ovf(ovf), .busy(busy), .mp3_req(mp3_req),
    .mp3_clk(mp3_clk), .mp3_dat(mp3_dat), .mp3_sync(mp3_sync)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  logic [7:0] exp_q[$];
  int   rises  = 0;
  int   nbits  = 0;
  logic [7:0] acc = 8'h00;
  logic [7:0] e_mon;
  logic prev_clk = 1'b0;

  task automatic chk(input string name, input int act, input int req);
    n_checks++;
    if (act == req) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, req);
  endtask

  // Monitor: rebuild serial bytes and pop the scoreboard
  always @(negedge clk) begin
    if (rst || !busy) nbits = 0;
    if (!rst && mp3_clk && !prev_clk) begin
      rises++;
      chk("sync_first_bit_only", int'(mp3_sync), int'(nbits == 0));
      acc = {acc[6:0], mp3_dat};
      nbits++;
      if (nbits == 8) begin
        nbits = 0;
        if (exp_q.size() == 0) begin
          chk("byte_unexpected", int'(acc), -1);
        end else begin
          e_mon = exp_q.pop_front();
          chk("byte_out", int'(acc), int'(e_mon));
        end
      end
    end
    prev_clk = mp3_clk;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_write(input logic [7:0] b, input bit accept);
    wr_stb  = 1'b1;
    wr_data = b;
    if (accept) exp_q.push_back(b);
    step();
    wr_stb = 1'b0;
  endtask

  task automatic wait_drain(input string name);
    for (int i = 0; i < 3000; i++) begin
      if (exp_q.size() == 0 && !busy) break;
      step();
    end
    chk(name, int'(exp_q.size() == 0 && !busy), 1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int r0;
    int held;
    int gaps;
    int sent;
    int maxlvl;

    rst = 1'b1; wr_stb = 1'b0; wr_data = 8'h00; flush = 1'b0;
    ovf_clr = 1'b0; mp3_req = 1'b0;

    // 1: reset with random inputs
    for (int i = 0; i < 4; i++) begin
      wr_stb  = 1'($urandom);
      wr_data = 8'($urandom);
      flush   = 1'($urandom);
      ovf_clr = 1'($urandom);
      mp3_req = 1'($urandom);
      step();
      chk("rst_level", int'(level), 0);
      chk("rst_flags", int'({full, empty, ovf, busy, mp3_clk, mp3_dat, mp3_sync}), 7'b0100000);
    end
    wr_stb = 1'b0; flush = 1'b0; ovf_clr = 1'b0; mp3_req = 1'b0;
    rst = 1'b0;
    step();
    chk("post_rst_level", int'(level), 0);
    chk("post_rst_empty", int'(empty), 1);

    // 2: single byte A5
    mp3_req = 1'b1;
    repeat (3) step();
    r0 = rises;
    do_write(8'hA5, 1'b1);
    chk("t2_level_after_write", int'(level), 1);
    chk("t2_empty_after_write", int'(empty), 0);
    step();
    chk("t2_start_busy_sync_dat", int'({busy, mp3_sync, mp3_dat}), 3'b111);
    repeat (16 * DIV - 1) step();
    chk("t2_busy_last_cycle", int'(busy), 1);
    step();
    chk("t2_busy_dropped", int'(busy), 0);
    chk("t2_rises", rises - r0, 8);
    chk("t2_sb_empty", exp_q.size(), 0);

    // 3: flow control
    mp3_req = 1'b0;
    repeat (3) step();
    r0 = rises;
    for (int i = 0; i < 3; i++) do_write(8'($urandom), 1'b1);
    repeat (5) step();
    chk("t3_level_held", int'(level), 3);
    chk("t3_no_clk_edges", rises - r0, 0);
    chk("t3_not_busy", int'(busy), 0);
    mp3_req = 1'b1;
    for (int i = 0; i < 10 && !busy; i++) step();
    chk("t3_started", int'(busy), 1);
    gaps = 0;
    for (int i = 0; i < 32 * DIV; i++) begin
      if (!busy) gaps++;
      if (i == 20 * DIV) mp3_req = 1'b0;
      step();
    end
    chk("t3_no_gap_between_bytes", gaps, 0);
    chk("t3_stopped_after_byte2", int'(busy), 0);
    chk("t3_byte3_held_level", int'(level), 1);
    chk("t3_sb_one_left", exp_q.size(), 1);
    mp3_req = 1'b1;
    wait_drain("t3_drain");

    // 4: overflow
    mp3_req = 1'b0;
    repeat (3) step();
    held = 0;
    for (int i = 0; i < 17; i++) begin
      do_write(8'(i), held < int'(DEPTH));
      if (held < int'(DEPTH)) held++;
    end
    chk("t4_full", int'(full), 1);
    chk("t4_level", int'(level), 16);
    chk("t4_ovf", int'(ovf), 1);
    ovf_clr = 1'b1;
    do_write(8'h99, 1'b0);
    chk("t4_ovf_set_beats_clr", int'(ovf), 1);
    step();
    ovf_clr = 1'b0;
    chk("t4_ovf_cleared", int'(ovf), 0);
    mp3_req = 1'b1;
    wait_drain("t4_drain");
    chk("t4_empty_after_drain", int'(empty), 1);

    // 5: random stream, pointer wrap
    sent = 0;
    maxlvl = 0;
    for (int c = 0; sent < 40 && c < 4000; c++) begin
      if (c % 5 == 0 && level < 14) begin
        wr_stb  = 1'b1;
        wr_data = 8'($urandom);
        exp_q.push_back(wr_data);
        sent++;
      end
      step();
      wr_stb = 1'b0;
      if (int'(level) > maxlvl) maxlvl = int'(level);
    end
    chk("t5_sent", sent, 40);
    wait_drain("t5_drain");
    chk("t5_level_le_depth", int'(maxlvl <= int'(DEPTH)), 1);
    do_write(8'h11, 1'b1);
    chk("t5_level_before_wp", int'(level), 1);
    do_write(8'h22, 1'b1);
    chk("t5_write_pop_level", int'(level), 1);
    chk("t5_write_pop_busy", int'(busy), 1);
    wait_drain("t5_wp_drain");

    // 6a: flush during bit 3
    do_write(8'hFF, 1'b1);
    do_write(8'h81, 1'b1);
    repeat (4 * 2 * DIV + 1) step();
    chk("t6_mid_byte_dat", int'(mp3_dat), 1);
    flush = 1'b1;
    step();
    flush = 1'b0;
    exp_q.delete();
    chk("t6_flush_outs", int'({mp3_clk, mp3_dat, mp3_sync, busy}), 0);
    chk("t6_flush_level", int'(level), 0);
    repeat (4) step();
    chk("t6_flush_stays_idle", int'(busy), 0);
    do_write(8'h3C, 1'b1);
    wait_drain("t6_flush_resend");

    // 6b: reset during bit 3
    do_write(8'hFF, 1'b1);
    do_write(8'h81, 1'b1);
    repeat (4 * 2 * DIV + 1) step();
    rst = 1'b1;
    #1;
    exp_q.delete();
    chk("t6_rst_outs", int'({mp3_clk, mp3_dat, mp3_sync, busy}), 0);
    chk("t6_rst_level", int'(level), 0);
    step();
    rst = 1'b0;
    step();
    do_write(8'h3C, 1'b1);
    wait_drain("t6_rst_resend");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
